// File: rtl/conv_host_mem.sv
// conv_host_mem: host-side image/L0/L1 memory responder and run handshake for the CONV engine.
// Build option CONV_HOST_BOUNDS_CHK_EN: enables the sticky err flag and drops out-of-range L1 writes.
module conv_host_mem #(
    parameter int DW       = 20,
    parameter int AW       = 12,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          img_we,
    input  logic [AW-1:0]                 img_waddr,
    input  logic [DW-1:0]                 img_wdata,
    output logic                          ready,
    input  logic                          busy,
    input  logic [AW-1:0]                 iaddr,
    output logic [DW-1:0]                 idata,
    input  logic [2:0]                    csel,
    input  logic                          cwr,
    input  logic [AW-1:0]                 caddr_wr,
    input  logic [DW-1:0]                 cdata_wr,
    input  logic                          crd,
    input  logic [AW-1:0]                 caddr_rd,
    output logic [DW-1:0]                 cdata_rd,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(L0_DEPTH):0]     l0_wr_cnt,
    output logic [$clog2(L1_DEPTH):0]     l1_wr_cnt
);
    localparam int L0AW = $clog2(L0_DEPTH);
    localparam int L1AW = $clog2(L1_DEPTH);
    localparam logic [L0AW:0] L0_MAX = (L0AW+1)'(L0_DEPTH);
    localparam logic [L1AW:0] L1_MAX = (L1AW+1)'(L1_DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state, state_nx;
    logic [DW-1:0] img_mem [0:(1<<AW)-1];
    logic [DW-1:0] l0_mem  [0:L0_DEPTH-1];
    logic [DW-1:0] l1_mem  [0:L1_DEPTH-1];
    logic          in_run, start_ok, sel_l0, sel_l1, l0_we, l1_we;

    assign in_run   = state == RUN;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign sel_l0   = csel == 3'b001;
    assign sel_l1   = csel == 3'b011;
    assign l0_we    = cwr && in_run && sel_l0;
    assign ready    = state == ARM;
    assign done     = state == DONE;
    assign idata    = img_mem[iaddr];
    assign cdata_rd = sel_l0 ? l0_mem[caddr_rd[L0AW-1:0]] : sel_l1 ? l1_mem[caddr_rd[L1AW-1:0]] : '0;

`ifdef CONV_HOST_BOUNDS_CHK_EN
    localparam logic [AW-1:0] L1_LIM = AW'(L1_DEPTH);
    logic l1_wr_oob, l1_rd_oob, err_hit, err_q;
    assign l1_wr_oob = caddr_wr >= L1_LIM;
    assign l1_rd_oob = caddr_rd >= L1_LIM;
    assign l1_we     = cwr && in_run && sel_l1 && !l1_wr_oob;
    assign err_hit   = (img_we && in_run) || (cwr && !in_run)
                     || ((cwr || crd) && !sel_l0 && !sel_l1)
                     || (sel_l1 && ((cwr && l1_wr_oob) || (crd && l1_rd_oob)));
    assign err       = err_q;
    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if (err_hit) err_q <= 1'b1;
    end
`else
    logic unused;
    assign unused = crd;
    assign l1_we  = cwr && in_run && sel_l1;
    assign err    = 1'b0;
`endif

    // Run handshake: start offers a run, busy high takes it, busy low finishes it.
    always_comb begin
        state_nx = start_ok ? ARM : (state == ARM && busy) ? RUN : (in_run && !busy) ? DONE : state;
    end

    // State register; reset from any state returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // Memory writes; image writes are locked out while the engine is running.
    always_ff @(posedge clk) begin
        if (img_we && !in_run) img_mem[img_waddr] <= img_wdata;
        if (l0_we) l0_mem[caddr_wr[L0AW-1:0]] <= cdata_wr;
        if (l1_we) l1_mem[caddr_wr[L1AW-1:0]] <= cdata_wr;
    end

    // Per-run saturating write counters, zeroed when a new run is offered.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            l0_wr_cnt <= '0;
            l1_wr_cnt <= '0;
        end else begin
            if (l0_we && l0_wr_cnt != L0_MAX) l0_wr_cnt <= l0_wr_cnt + 1'b1;
            if (l1_we && l1_wr_cnt != L1_MAX) l1_wr_cnt <= l1_wr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_host_mem.sv
// tb_conv_host_mem: directed + randomized self-checking bench for conv_host_mem.
module tb_conv_host_mem;
    localparam int DW = 20;
    localparam int AW = 12;
`ifdef CONV_HOST_BOUNDS_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, img_we, busy, cwr, crd;
    logic [AW-1:0] img_waddr, iaddr, caddr_wr, caddr_rd;
    logic [DW-1:0] img_wdata, idata, cdata_wr, cdata_rd;
    logic [2:0] csel;
    logic ready, done, err;
    logic [12:0] l0_wr_cnt;
    logic [10:0] l1_wr_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] img_m [4096];
    logic [DW-1:0] l0_m [4096];
    logic [DW-1:0] l1_m [1024];
    bit l0_v [4096];
    bit l1_v [1024];
    int l0_c, l1_c;
    bit err_m, run_m;

    always #5 clk = ~clk;

    conv_host_mem dut (
        .clk(clk), .reset(reset), .start(start), .img_we(img_we), .img_waddr(img_waddr),
        .img_wdata(img_wdata), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .done(done), .err(err),
        .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit rdy, input bit dn);
        chk({tag, ".ready"}, 32'(ready), 32'(rdy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".err"}, 32'(err), 32'(err_m));
        chk({tag, ".l0cnt"}, 32'(l0_wr_cnt), l0_c);
        chk({tag, ".l1cnt"}, 32'(l1_wr_cnt), l1_c);
    endtask

    function automatic logic [DW-1:0] exp_rd();
        if (csel == 3'b001) return l0_m[caddr_rd];
        if (csel == 3'b011) return l1_m[int'(caddr_rd) % 1024];
        return '0;
    endfunction

    function automatic bit rd_known();
        if (csel == 3'b001) return l0_v[caddr_rd];
        if (csel == 3'b011) return l1_v[int'(caddr_rd) % 1024];
        return 1'b1;
    endfunction

    // Apply the effect of the currently driven inputs to the model, then advance one clock.
    task automatic tick();
        if (reset) begin
            err_m = 0; l0_c = 0; l1_c = 0; run_m = 0;
        end else begin
            if (img_we) begin
                if (run_m) err_m |= CHK;
                else img_m[img_waddr] = img_wdata;
            end
            if (crd && csel != 3'b001 && csel != 3'b011) err_m |= CHK;
            if (crd && csel == 3'b011 && caddr_rd >= 12'd1024) err_m |= CHK;
            if (cwr) begin
                if (!run_m) err_m |= CHK;
                else if (csel == 3'b001) begin
                    l0_m[caddr_wr] = cdata_wr; l0_v[caddr_wr] = 1;
                    if (l0_c < 4096) l0_c++;
                end else if (csel == 3'b011 && !(CHK && caddr_wr >= 12'd1024)) begin
                    l1_m[int'(caddr_wr) % 1024] = cdata_wr; l1_v[int'(caddr_wr) % 1024] = 1;
                    if (l1_c < 1024) l1_c++;
                end else err_m |= CHK;
            end
        end
        @(posedge clk); #1;
        img_we = 0; cwr = 0; crd = 0; start = 0;
    endtask

    initial begin
        logic [DW-1:0] v;
        reset = 1; start = 0; img_we = 0; busy = 0; cwr = 0; crd = 0; csel = 0;
        img_waddr = 0; img_wdata = 0; iaddr = 0; caddr_wr = 0; caddr_rd = 0; cdata_wr = 0;
        tick(); tick();
        reset = 0; #1;
        chk_status("reset", 0, 0);

        for (int i = 0; i < 4096; i++) begin
            img_we = 1; img_waddr = AW'(i); img_wdata = DW'(i); tick();
        end
        iaddr = 130; #1; chk("idata_130", 32'(idata), 32'd130);
        iaddr = 4095; #1; chk("idata_4095", 32'(idata), 32'd4095);
        tick();
        for (int i = 0; i < 16; i++) begin
            img_we = 1; img_waddr = AW'($urandom_range(0, 4095)); img_wdata = DW'($urandom);
            iaddr = (i % 2 == 0) ? img_waddr : AW'($urandom_range(0, 4095)); #1;
            chk("idata_rand", 32'(idata), 32'(img_m[iaddr]));
            tick();
        end

        busy = 1; tick(); tick(); tick();
        chk("busy_in_idle.ready", 32'(ready), 32'd0);
        busy = 0;

        start = 1; tick();
        chk_status("arm", 1, 0);
        for (int i = 0; i < 4; i++) begin
            start = 1; tick();
            chk("arm_hold.ready", 32'(ready), 32'd1);
        end
        busy = 1; tick(); run_m = 1;
        chk_status("run_enter", 0, 0);
        start = 1; tick();
        chk("start_in_run.ready", 32'(ready), 32'd0);

        csel = 3'b001; cwr = 1; caddr_wr = 5; cdata_wr = 20'h1234A; tick();
        crd = 1; caddr_rd = 5; #1;
        chk("l0_rd5", 32'(cdata_rd), 32'h1234A);
        chk("l0_cnt1", 32'(l0_wr_cnt), 32'd1);
        tick();

        csel = 3'b011; cwr = 1; caddr_wr = 3; cdata_wr = 20'h00002; tick();
        cwr = 1; caddr_wr = 3; cdata_wr = 20'h00007; crd = 1; caddr_rd = 3; #1;
        chk("coll_old", 32'(cdata_rd), 32'h2);
        tick();
        chk("coll_new", 32'(cdata_rd), 32'h7);

        v = DW'($urandom);
        csel = 3'b011; cwr = 1; caddr_wr = 476; cdata_wr = v; tick();
        csel = 3'b010; cwr = 1; caddr_wr = 9; cdata_wr = DW'($urandom); caddr_rd = 5; #1;
        chk("unmapped_rd", 32'(cdata_rd), 32'd0);
        tick();
        chk_status("unmapped_wr", 0, 0);
        csel = 3'b011; cwr = 1; caddr_wr = 1500; cdata_wr = ~v; tick();
        caddr_rd = 476; #1;
        chk("l1_1500_alias", 32'(cdata_rd), 32'(l1_m[476]));
        chk_status("l1_1500", 0, 0);

        for (int i = 0; i < 300; i++) begin
            csel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ($urandom_range(0, 1) ? 3'b001 : 3'b011);
            cwr = 1'($urandom); crd = 1'($urandom);
            caddr_wr = AW'($urandom_range(0, 31)); cdata_wr = DW'($urandom);
            caddr_rd = $urandom_range(0, 2) == 0 ? caddr_wr : AW'($urandom_range(0, 31));
            #1;
            if (rd_known()) chk("rand_rd", 32'(cdata_rd), 32'(exp_rd()));
            tick();
        end
        chk_status("rand_end", 0, 0);

        for (int i = 0; i < 1030; i++) begin
            csel = 3'b011; cwr = 1; caddr_wr = AW'($urandom_range(0, 1023)); cdata_wr = DW'($urandom); tick();
        end
        chk("l1_sat", 32'(l1_wr_cnt), 32'd1024);
        for (int i = 0; i < 4100; i++) begin
            csel = 3'b001; cwr = 1; caddr_wr = AW'($urandom_range(0, 4095)); cdata_wr = DW'($urandom); tick();
        end
        chk("l0_sat", 32'(l0_wr_cnt), 32'd4096);
        csel = 3'b011; caddr_rd = AW'($urandom_range(0, 1023)); #1;
        chk("l1_rd_after_sat", 32'(cdata_rd), 32'(exp_rd()));

        v = ~img_m[130];
        img_we = 1; img_waddr = 130; img_wdata = v; tick();
        iaddr = 130; #1;
        chk("img_we_in_run", 32'(idata), 32'(img_m[130]));
        chk_status("img_we_in_run", 0, 0);

        busy = 0; tick(); run_m = 0;
        chk_status("run_end", 0, 1);
        tick();
        chk_status("done_hold", 0, 1);

        img_we = 1; img_waddr = 7; img_wdata = DW'($urandom); tick();
        iaddr = 7; #1;
        chk("img_we_in_done", 32'(idata), 32'(img_m[7]));
        csel = 3'b001; cwr = 1; caddr_wr = 5; cdata_wr = ~l0_m[5]; tick();
        caddr_rd = 5; #1;
        chk("cwr_in_done_rd", 32'(cdata_rd), 32'(l0_m[5]));
        chk_status("cwr_in_done", 0, 1);

        start = 1; tick(); l0_c = 0; l1_c = 0;
        chk_status("restart", 1, 0);
        busy = 1; tick(); run_m = 1;
        csel = 3'b001; cwr = 1; caddr_wr = 5; cdata_wr = 20'h1234A; tick();
        chk_status("run2", 0, 0);
        reset = 1; tick();
        reset = 0; #1;
        chk_status("reset_mid_run", 0, 0);
        caddr_rd = 5; csel = 3'b001; #1;
        chk("retained_l0_5", 32'(cdata_rd), 32'h1234A);
        tick(); tick();
        chk("ready_after_reset", 32'(ready), 32'd0);

        csel = 3'b001; cwr = 1; caddr_wr = 5; cdata_wr = 20'h0; tick();
        caddr_rd = 5; #1;
        chk("cwr_in_idle_rd", 32'(cdata_rd), 32'h1234A);
        chk_status("cwr_in_idle", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_host_mem.md
# conv_host_mem

Host-side responder for the `CONV` engine's memory interface. It owns the 4096×20 input image RAM, the layer-0 bank (L0, 4096×20) and the layer-1 bank (L1, 1024×20), and drives the `ready` handshake that starts a run. It answers the engine's `iaddr`, `cwr`/`crd`/`csel` traffic and reports completion when `busy` falls. It sits between the system host (image load, start, done) and the convolution engine.

## Interface
Parameters:
- `DW`, 20, data width of all memories
- `AW`, 12, address width of `iaddr`, `caddr_wr`, `caddr_rd`
- `L0_DEPTH`, 4096, L0 entries
- `L1_DEPTH`, 1024, L1 entries

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: host run request, 1-cycle pulse.
- `img_we` in 1: image RAM write enable.
- `img_waddr` in AW: image write address.
- `img_wdata` in DW: image write data.
- `ready` out 1: run offered to the engine.
- `busy` in 1: engine active flag.
- `iaddr` in AW: image read address.
- `idata` out DW: image read data.
- `csel` in 3: bank select. 001 selects L0; 011 selects L1; all other codes are unmapped.
- `cwr` in 1: layer write strobe.
- `caddr_wr` in AW: layer write address.
- `cdata_wr` in DW: layer write data.
- `crd` in 1: layer read strobe.
- `caddr_rd` in AW: layer read address.
- `cdata_rd` out DW: layer read data.
- `done` out 1: run finished. Held until the next `start` or `reset`.
- `err` out 1: sticky protocol error flag.
- `l0_wr_cnt` out 13: count of accepted L0 writes in the current run.
- `l1_wr_cnt` out 11: count of accepted L1 writes in the current run.

## Operation
- **FSM states:** IDLE, ARM, RUN, DONE. Reset forces IDLE.
- **IDLE** (`ready`=0): `img_we` writes the image RAM. `start` moves to ARM.
- **ARM** (`ready`=1): when `busy`=1 is sampled, move to RUN. `ready` is 0 from the next cycle.
- **RUN:**
  - Serves the engine.
  - `img_we` is ignored and sets `err`.
  - When `busy`=0 is sampled, move to DONE.
- **DONE** (`done`=1): `img_we` is accepted. `start` moves to ARM, clears `done`, and zeroes both write counters.
- **Image read:** `idata` = img[`iaddr`], combinational (asynchronous read), valid in any state.
- **Layer read:** `cdata_rd` = bank[`caddr_rd`], combinational, for the bank selected by `csel`. The value does not depend on `crd`. For an unmapped `csel`, `cdata_rd` = 0.
- **Layer write:** when `cwr`=1 and `csel` is mapped, bank[`caddr_wr`] <= `cdata_wr` at the clock edge. The matching counter increments. Counters saturate at 4096 (L0) and 1024 (L1).
- **Writes outside RUN:** `cwr` outside RUN is ignored and sets `err`.
- **Read/write to the same address in the same cycle:** `cdata_rd` shows the old value. The new value is visible the following cycle.
- **L1 addressing:** only `caddr[9:0]` is used for L1 (see Configuration for out-of-range handling).
- **Data handling:** data is stored verbatim with no sign or width conversion.
- **Reset values:** `ready`=0, `done`=0, `err`=0, counters=0. Reset does not clear memory contents.
- **Reset mid-RUN:** the FSM returns to IDLE next cycle and `ready` stays 0. Already-written bank contents are retained.

## Timing
- **Start to ready:** `start` at edge N gives `ready`=1 from edge N+1.
- **Busy to ready drop:** `busy`=1 sampled at edge M gives `ready`=0 from edge M+1.
- **Run end:** `busy` 1→0 sampled at edge K gives `done`=1 from edge K+1.
- **Read latency:** `idata` and `cdata_rd` have zero-cycle latency. The engine registers its address and captures the data at the next edge.
- **Counters and `err`:** update at the edge on which the triggering strobe is sampled.
- **`busy` already 1 in IDLE:** no effect; ARM is entered only through `start`.
- **`start` during ARM or RUN:** ignored.

## Configuration
- **`CONV_HOST_BOUNDS_CHK_EN` defined:**
  - The following set `err`: an unmapped `csel` with `cwr` or `crd`; an L1 access with `caddr`≥`L1_DEPTH`; `cwr` outside RUN; `img_we` in RUN.
  - Out-of-range L1 writes are dropped and not counted.
- **`CONV_HOST_BOUNDS_CHK_EN` undefined:**
  - `err` is tied 0.
  - L1 addresses wrap modulo `L1_DEPTH`, and those writes are counted.
  - Unmapped-`csel` writes and out-of-RUN `cwr` are still dropped silently.

## Test plan
- **Image load and read:** load img[0..4095]=index via `img_we`, then drive `iaddr`=130 → `idata`=130 in the same cycle. `iaddr`=4095 → 4095.
- **Handshake:** `start` at cycle 10, then `busy`=1 at cycle 15 → `ready`=1 for cycles 11–15, 0 from cycle 16. Dropping `busy` at cycle 100 → `done`=1 from cycle 101.
- **L0 write and read:** in RUN, `csel`=001, `cwr`=1, `caddr_wr`=5, `cdata_wr`=20'h1234A; then `csel`=001, `caddr_rd`=5 → `cdata_rd`=20'h1234A and `l0_wr_cnt`=1.
- **Same-address collision:** same-cycle write of 20'h00007 and read of L1 address 3 (old 20'h00002) → `cdata_rd`=20'h00002, then 20'h00007 next cycle.
- **Error cases (macro on):** `cwr` with `csel`=010 → `err`=1 and no counter change. L1 write at `caddr_wr`=1500 → dropped and `err`=1. With the macro off, the same L1 write lands at address 476 and `err`=0.
- **Reset mid-RUN:** assert `reset` mid-RUN → `ready`=0, `done`=0, counters=0, and a previously written L0 address 5 still reads 20'h1234A.
